// File: rtl/subframe_seq_pkg.sv
// rtl/subframe_seq_pkg.sv - state encodings and synchroniser depth for the subframe sequencer
package subframe_seq_pkg;

    localparam int SYNC_DEPTH = 2;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_REQ    = 3'd2;
    localparam logic [2:0] ST_EXPOSE = 3'd3;
    localparam logic [2:0] ST_WAIT0  = 3'd4;
    localparam logic [2:0] ST_ACK0   = 3'd5;
    localparam logic [2:0] ST_NEXT   = 3'd6;

endpackage

// File: rtl/subframe_seq_fsm_if.sv
// rtl/subframe_seq_fsm_if.sv - pattern FIFO, MSTREAM lanes and sensor handshake bundle
interface subframe_seq_fsm_if #(
    parameter int LANES = 10
);
    logic [LANES-1:0] pat_data;
    logic             pat_valid;
    logic             pat_ready;
    logic [LANES-1:0] mstream;
    logic             stream;
    logic             fsmind1;
    logic             fsmind1_ack;
    logic             fsmind0;
    logic             fsmind0_ack;

    modport master (
        input  pat_data, pat_valid, fsmind1_ack, fsmind0,
        output pat_ready, mstream, stream, fsmind1, fsmind0_ack
    );

    modport slave (
        output pat_data, pat_valid, fsmind1_ack, fsmind0,
        input  pat_ready, mstream, stream, fsmind1, fsmind0_ack
    );
endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - flop-chain synchroniser for asynchronous sensor handshake inputs
module sync2
    import subframe_seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [SYNC_DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[SYNC_DEPTH-2:0], d};
        end
    end

    assign q = sr[SYNC_DEPTH-1];
endmodule

// File: rtl/subframe_seq_fsm.sv
// rtl/subframe_seq_fsm.sv - coded-exposure subframe sequencer: pattern streaming, sensor handshakes, exposure timing
module subframe_seq_fsm
    import subframe_seq_pkg::*;
#(
    parameter int LANES   = 10,
    parameter int BEATS   = 18,
    parameter int MAX_PAT = 16,
    parameter int EXP_W   = 32,
    parameter int PAT_W   = $clog2(MAX_PAT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 mode_cont,
    input  logic [PAT_W-1:0]     num_pat,
    input  logic [EXP_W-1:0]     exp_cycles,
    subframe_seq_fsm_if.master   bus,
    output logic                 busy,
    output logic [PAT_W-1:0]     subframe_idx,
    output logic                 frame_done,
    output logic                 err_underrun
);
    localparam int BEAT_W = $clog2(BEATS + 1);

    state_t             state;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [EXP_W-1:0]   exp_cnt;
    logic [EXP_W-1:0]   exp_last;
    logic [PAT_W-1:0]   num_pat_q;
    logic               mode_cont_q;
    logic               stop_pending;
    logic               ack1_s;
    logic               ind0_s;
    logic               start_ok;
    logic               last_sub;
    logic               stop_now;

    sync2 u_sync_ack1 (.clk(clk), .rst_n(rst_n), .d(bus.fsmind1_ack), .q(ack1_s));
    sync2 u_sync_ind0 (.clk(clk), .rst_n(rst_n), .d(bus.fsmind0),     .q(ind0_s));

    assign start_ok = start && (num_pat != '0) && (num_pat <= PAT_W'(MAX_PAT));
    assign last_sub = (subframe_idx + PAT_W'(1)) >= num_pat_q;
    assign stop_now = stop_pending || stop;

    assign busy            = (state != ST_IDLE);
    assign bus.pat_ready   = (state == ST_LOAD) && bus.pat_valid;
    assign bus.fsmind1     = (state == ST_REQ) || (state == ST_EXPOSE);
    assign bus.fsmind0_ack = (state == ST_ACK0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            beat_cnt     <= '0;
            exp_cnt      <= '0;
            exp_last     <= '0;
            num_pat_q    <= '0;
            mode_cont_q  <= 1'b0;
            stop_pending <= 1'b0;
            subframe_idx <= '0;
            frame_done   <= 1'b0;
            err_underrun <= 1'b0;
            bus.mstream  <= '0;
            bus.stream   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            bus.stream <= 1'b0;
            if (state != ST_IDLE && stop) begin
                stop_pending <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    // a stop arriving with the start still lets the first subframe run
                    stop_pending <= start_ok && stop;
                    if (start_ok) begin
                        num_pat_q    <= num_pat;
                        exp_last     <= (exp_cycles == '0) ? '0 : exp_cycles - EXP_W'(1);
                        mode_cont_q  <= mode_cont;
                        err_underrun <= 1'b0;
                        subframe_idx <= '0;
                        beat_cnt     <= '0;
                        state        <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (bus.pat_valid) begin
                        bus.mstream <= bus.pat_data;
                        bus.stream  <= 1'b1;
                        if (beat_cnt == BEAT_W'(BEATS - 1)) begin
                            beat_cnt <= '0;
                            state    <= ST_REQ;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end else begin
                        err_underrun <= 1'b1;
                    end
                end
                ST_REQ: begin
                    exp_cnt <= '0;
                    if (ack1_s) begin
                        state <= ST_EXPOSE;
                    end
                end
                ST_EXPOSE: begin
                    if (exp_cnt >= exp_last) begin
                        state <= ST_WAIT0;
                    end else begin
                        exp_cnt <= exp_cnt + EXP_W'(1);
                    end
                end
                ST_WAIT0: begin
                    if (ind0_s) begin
                        state <= ST_ACK0;
                    end
                end
                ST_ACK0: begin
                    if (!ind0_s && !ack1_s) begin
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (!last_sub) begin
                        if (stop_now) begin
                            state <= ST_IDLE;
                        end else begin
                            subframe_idx <= subframe_idx + PAT_W'(1);
                            state        <= ST_LOAD;
                        end
                    end else begin
                        frame_done <= 1'b1;
                        if (mode_cont_q && !stop_now) begin
                            subframe_idx <= '0;
                            state        <= ST_LOAD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/subframe_seq_fsm.md
Name: subframe_seq_fsm

Overview:
Parametrised successor to the imager memory-FSM handshake logic. Sequences 1..MAX_PAT coded-exposure subframes per frame. For each subframe it streams a pattern from the pattern FIFO onto the MSTREAM lanes, runs the FSMIND1/FSMIND1ACK then FSMIND0/FSMIND0ACK handshakes with the sensor, and times the exposure. Adds runtime subframe count, configurable lane width and beats, continuous-repeat mode, graceful stop, and underrun detection.

Parameters:
LANES, 10, MSTREAM lanes driven per beat
BEATS, 18, beats per pattern (rows shifted per subframe)
MAX_PAT, 16, maximum subframes per frame
EXP_W, 32, exposure counter width
PAT_W, $clog2(MAX_PAT+1), width of num_pat

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame sequence from IDLE
stop  in  1  one-cycle pulse; finish current subframe, then return to IDLE
mode_cont  in  1  1 = repeat frames until stop; 0 = one frame
num_pat  in  PAT_W  subframes per frame, sampled at start
exp_cycles  in  EXP_W  exposure length in clk cycles, sampled at start
pat_data  in  LANES  pattern FIFO data
pat_valid  in  1  pattern FIFO not empty
pat_ready  out  1  pop strobe to pattern FIFO
mstream  out  LANES  pattern lanes to sensor
stream  out  1  qualifies mstream, high for each accepted beat
fsmind1  out  1  "pattern loaded" request to sensor
fsmind1_ack  in  1  sensor ack, asynchronous
fsmind0  in  1  sensor "exposure done", asynchronous
fsmind0_ack  out  1  ack to sensor
busy  out  1  high in every state except IDLE
subframe_idx  out  PAT_W  current subframe, 0-based
frame_done  out  1  one-cycle pulse after last subframe's ACK0
err_underrun  out  1  sticky; cleared on accepted start

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, latched config 0.
- fsmind1_ack and fsmind0 each pass through a 2-flop synchroniser. Internal logic sees a 2-cycle delay.
- IDLE: on start with num_pat in 1..MAX_PAT, latch num_pat/exp_cycles/mode_cont, clear err_underrun, subframe_idx=0, go LOAD. Ignore start when num_pat=0 or num_pat>MAX_PAT.
- LOAD: pat_ready=pat_valid. On each pat_valid cycle: mstream<=pat_data, stream<=1 (registered, 1-cycle latency), beat++. If pat_valid=0: stream=0, stall, set err_underrun. After BEATS accepted beats, go REQ.
- REQ: fsmind1=1 until synced ack=1, then go EXPOSE.
- EXPOSE: fsmind1=1 is held. Count max(exp_cycles,1) cycles, then drop fsmind1 and go WAIT0.
- WAIT0: wait for synced fsmind0=1, then go ACK0.
- ACK0: fsmind0_ack=1 until synced fsmind0=0 and synced fsmind1_ack=0, then drop fsmind0_ack and go NEXT.
- NEXT: if subframe_idx<num_pat-1, increment and go LOAD. Otherwise pulse frame_done. If mode_cont and no stop is pending, set idx=0 and go LOAD; otherwise go IDLE.
- stop: latched as stop_pending in any non-IDLE state. Takes effect only at NEXT, which goes to IDLE. Does not emit frame_done unless the frame completed. Cleared in IDLE.
- start while busy: ignored.
- start and stop in the same cycle in IDLE: frame starts, then stops after its first subframe.
- rst_n low mid-handshake: immediate return to IDLE with all handshake outputs 0. No FIFO pop on the reset edge.

Decomposition:
- Package subframe_seq_pkg: state enum (IDLE, LOAD, REQ, EXPOSE, WAIT0, ACK0, NEXT) and the synchroniser depth constant (2).
- Sub-module sync2 (2-flop synchroniser), instantiated twice.

Test Plan:
- num_pat=1, exp=20, FIFO full, sensor acks fsmind1 after 1000 cycles and raises fsmind0 2000 cycles later -> 18 stream beats with data matching the FIFO. fsmind1 high until exposure count ends. fsmind0_ack asserted 2 cycles after fsmind0. frame_done after ACK0. busy falls.
- num_pat=3, exp=0 -> 54 beats total, subframe_idx steps 0,1,2, EXPOSE lasts 1 cycle each, exactly one frame_done pulse.
- pat_valid deasserted for 5 cycles at beat 7 -> stream gap of 5 cycles, still 18 beats total, err_underrun=1 until the next start.
- mode_cont=1, num_pat=2, stop pulsed during subframe 1 of frame 2 -> frame 2 completes with frame_done, then IDLE. No third frame.
- rst_n asserted during REQ -> fsmind1, stream, busy all 0 immediately. A fresh start then runs a full sequence.
- start with num_pat=0 -> stays IDLE, busy=0, pat_ready never asserted.
